csr_exec_unit: RTL and testbench
================================

Name: csr_exec_unit

Overview:
- Executes Zicsr instructions (CSRRW/S/C and the immediate forms) for the RV32I core, between decode/issue and the CSR register file.
- Accepts one request via valid/ready, reads the old CSR value, computes and writes the new value, then returns the old value for rd writeback.
- Owns the register file's read and write ports. Read-only and illegal-encoding checks are done here.

Parameters:
- XLEN, 32, data width of CSR values and rs1 operand.
- RO_CHECK, 1, when 1, flag writes to read-only CSRs (addr[11:10]==2'b11) as illegal.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_funct3  in  3  instruction funct3
- in_csr_addr  in  12  CSR address (inst[31:20])
- in_src_idx  in  5  rs1 index / zimm field (inst[19:15])
- in_rs1_val  in  XLEN  rs1 register value
- in_rd  in  5  destination register
- csr_r_addr  out  12  register file read address
- csr_r_val  in  XLEN  register file read data (combinational)
- csr_w_addr  out  12  register file write address
- csr_w_val  out  XLEN  register file write data
- csr_w_en  out  1  register file write enable
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_rd  out  5  destination register
- out_val  out  XLEN  old CSR value (0 if illegal)
- out_illegal  out  1  illegal-instruction flag

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - state=IDLE.
  - All request and result registers clear to 0.
  - out_valid=0, csr_w_en=0, csr_r_addr=0, csr_w_addr=0, csr_w_val=0.
  - in_ready=0 while reset is low, 1 once in IDLE.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: in_ready=1. On in_valid, capture funct3, addr, src_idx, rd and operand, then go to READ.
    - operand = in_rs1_val for funct3[2]=0.
    - operand = zero-extended in_src_idx for funct3[2]=1.
  - READ: csr_r_addr=captured addr. Latch csr_r_val into old_q, then go to WRITE.
  - WRITE: compute new value from old_q and operand:
    - RW: new = operand
    - RS: new = old | operand
    - RC: new = old & ~operand
    - csr_w_en = do_write & ~illegal, for exactly this one cycle. Then go to RESP.
  - RESP: out_valid=1, with out_rd, out_val=old_q (0 if illegal), out_illegal.
    - Outputs hold stable until out_ready=1.
    - On out_ready with in_valid=0: go to IDLE.
    - On out_ready with in_valid=1: in_ready=1, accept the new request the same cycle, go to READ (back-to-back).
- csr_w_addr and csr_w_val come from registers and are valid only when csr_w_en=1.
- csr_r_addr is held at the captured addr outside READ.
- Latency: accept edge T, READ in T+1, write in T+2, out_valid from T+3. Throughput is one op per 3 cycles with out_ready=1.
- do_write rules:
  - RW and RWI always write.
  - RS, RC, RSI and RCI write only when src_idx != 0.
- Illegal (out_illegal=1, no write, out_val=0):
  - funct3 is 000 or 100.
  - RO_CHECK=1, addr[11:10]==2'b11, and do_write=1.
  - A read of a read-only CSR with do_write=0 is legal.
- Back-to-back same-address ops: the second READ occurs after the first WRITE edge, so it observes the new value. No forwarding is needed.
- Reset mid-operation: the FSM returns to IDLE immediately and csr_w_en drops combinationally. No partial or late write; the pending result is discarded.
- in_valid during READ or WRITE is ignored (in_ready=0). Upstream must hold the request.

Decomposition:
- Shared def.v additions:
  - Funct3 codes: CSRRW=3'b001, CSRRS=3'b010, CSRRC=3'b011, CSRRWI=3'b101, CSRRSI=3'b110, CSRRCI=3'b111.
  - FSM state encodings: IDLE=2'd0, READ=2'd1, WRITE=2'd2, RESP=2'd3.
  - CSR_MSCRATCH_ADDR=12'h340.
  - CSR_MVENDORID_ADDR=12'hF11.
- Sub-module csr_alu (combinational): funct3, old, operand, src_idx -> new_val, do_write, illegal. Unit-testable alone.

Test Plan:
- CSRRW 0x340 (old 0x000000F0), rs1_val=0x12345678, rd=5: w_en one cycle at T+2 with addr 0x340, val 0x12345678. At T+3: out_valid, out_rd=5, out_val=0x000000F0, out_illegal=0.
- CSRRS 0x340 (old 0x0000F0F0), rs1_val=0x0F0F0000, src_idx=3 then CSRRC with rs1_val=0x000000F0, back-to-back with out_ready=1:
  - First writes 0x0F0FF0F0 and returns 0x0000F0F0.
  - Second returns 0x0F0FF0F0 and writes 0x0F0FF000.
- CSRRSI with zimm=0 on 0xF11 (old 0x00000F11): no w_en, out_val=0x00000F11, out_illegal=0. CSRRWI zimm=7 on 0xF11: no w_en, out_illegal=1, out_val=0.
- funct3=3'b100: out_illegal=1, no write. out_ready held 0 for 4 cycles: out_valid and outputs stable, in_ready=0 throughout.
- Assert reset=0 during the WRITE cycle: csr_w_en drops immediately, register file unchanged, out_valid stays 0, in_ready=1 after release.

Source files
------------

// File: rtl/csr_exec_unit_pkg.sv
// Shared definitions for the Zicsr execution unit: funct3 codes, FSM encodings,
// well-known CSR addresses and the captured request layout.
package csr_exec_unit_pkg;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [11:0] CSR_MSCRATCH_ADDR  = 12'h340;
    localparam logic [11:0] CSR_MVENDORID_ADDR = 12'hF11;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [11:0] addr;
        logic [4:0]  src_idx;
        logic [4:0]  rd;
    } csr_req_t;

    // CSRs in the 0xC00-0xFFF window are read-only by address convention
    function automatic logic is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_exec_unit_if.sv
// Bundle of the issue-side handshake, result handshake and CSR register file ports.
// master = issue logic / register file side, slave = execution unit.
interface csr_exec_unit_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [11:0]     in_csr_addr;
    logic [4:0]      in_src_idx;
    logic [XLEN-1:0] in_rs1_val;
    logic [4:0]      in_rd;
    logic [11:0]     csr_r_addr;
    logic [XLEN-1:0] csr_r_val;
    logic [11:0]     csr_w_addr;
    logic [XLEN-1:0] csr_w_val;
    logic            csr_w_en;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_val;
    logic            out_illegal;

    modport master (
        output in_valid, in_funct3, in_csr_addr, in_src_idx, in_rs1_val, in_rd,
        output csr_r_val, out_ready,
        input  in_ready, csr_r_addr, csr_w_addr, csr_w_val, csr_w_en,
        input  out_valid, out_rd, out_val, out_illegal
    );

    modport slave (
        input  in_valid, in_funct3, in_csr_addr, in_src_idx, in_rs1_val, in_rd,
        input  csr_r_val, out_ready,
        output in_ready, csr_r_addr, csr_w_addr, csr_w_val, csr_w_en,
        output out_valid, out_rd, out_val, out_illegal
    );
endinterface

// File: rtl/csr_exec_unit_alu.sv
// Combinational Zicsr datapath: new CSR value, whether the op writes, and
// whether the encoding / target makes the instruction illegal.
module csr_exec_unit_alu
    import csr_exec_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RO_CHECK = 1
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] operand,
    input  logic [4:0]      src_idx,
    input  logic            ro_csr,
    output logic [XLEN-1:0] new_val,
    output logic            do_write,
    output logic            illegal
);
    logic bad_op;

    always_comb begin
        new_val  = old_val;
        do_write = 1'b0;
        bad_op   = 1'b0;
        unique case (funct3)
            F3_CSRRW, F3_CSRRWI: begin
                new_val  = operand;
                do_write = 1'b1;
            end
            // set/clear with x0 / zimm=0 is a pure read and must not write
            F3_CSRRS, F3_CSRRSI: begin
                new_val  = old_val | operand;
                do_write = |src_idx;
            end
            F3_CSRRC, F3_CSRRCI: begin
                new_val  = old_val & ~operand;
                do_write = |src_idx;
            end
            default: bad_op = 1'b1;
        endcase
    end

    assign illegal = bad_op || ((RO_CHECK != 0) && ro_csr && do_write);

endmodule

// File: rtl/csr_exec_unit.sv
// Zicsr execution unit: sequences read / write / respond against the CSR
// register file, one instruction at a time.
//
// state | meaning
// IDLE  | ready for a request
// READ  | csr_r_addr presented, old value latched at end of cycle
// WRITE | csr_w_en pulsed if the op writes and is legal
// RESP  | result held on out_* until out_ready; may accept next request
module csr_exec_unit
    import csr_exec_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RO_CHECK = 1
) (
    input  logic          clock,
    input  logic          reset,
    csr_exec_unit_if.slave bus
);
    logic [1:0]      state_q;
    csr_req_t        req_q;
    logic [XLEN-1:0] operand_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] w_val_q;
    logic            illegal_q;
    logic            do_write_q;

    logic [XLEN-1:0] new_val;
    logic            do_write;
    logic            illegal;
    logic            accept;
    logic [XLEN-1:0] in_operand;

    csr_exec_unit_alu #(.XLEN(XLEN), .RO_CHECK(RO_CHECK)) u_alu (
        .funct3   (req_q.funct3),
        .old_val  (bus.csr_r_val),
        .operand  (operand_q),
        .src_idx  (req_q.src_idx),
        .ro_csr   (is_read_only(req_q.addr)),
        .new_val  (new_val),
        .do_write (do_write),
        .illegal  (illegal)
    );

    assign bus.in_ready = reset && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_RESP) && bus.out_ready));
    assign accept       = bus.in_ready && bus.in_valid;
    assign in_operand   = bus.in_funct3[2] ? {{(XLEN-5){1'b0}}, bus.in_src_idx}
                                           : bus.in_rs1_val;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            operand_q  <= '0;
            old_q      <= '0;
            w_val_q    <= '0;
            illegal_q  <= 1'b0;
            do_write_q <= 1'b0;
        end else begin
            if (accept) begin
                req_q.funct3  <= bus.in_funct3;
                req_q.addr    <= bus.in_csr_addr;
                req_q.src_idx <= bus.in_src_idx;
                req_q.rd      <= bus.in_rd;
                operand_q     <= in_operand;
            end
            unique case (state_q)
                ST_IDLE: if (accept) state_q <= ST_READ;
                ST_READ: begin
                    // write data is registered here so WRITE drives only flops
                    old_q      <= bus.csr_r_val;
                    w_val_q    <= new_val;
                    illegal_q  <= illegal;
                    do_write_q <= do_write;
                    state_q    <= ST_WRITE;
                end
                ST_WRITE: state_q <= ST_RESP;
                ST_RESP: begin
                    if (bus.out_ready) state_q <= accept ? ST_READ : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.csr_r_addr  = req_q.addr;
    assign bus.csr_w_addr  = req_q.addr;
    assign bus.csr_w_val   = w_val_q;
    assign bus.csr_w_en    = reset && (state_q == ST_WRITE) && do_write_q && !illegal_q;

    assign bus.out_valid   = (state_q == ST_RESP);
    assign bus.out_rd      = req_q.rd;
    assign bus.out_val     = illegal_q ? '0 : old_q;
    assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: CSR file model on the read/write ports,
// reference model feeding result and write scoreboards.
module tb_csr_exec_unit;
    import csr_exec_unit_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        ill;
    } res_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] val;
    } wr_t;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rf  [4096];
    logic [31:0] mdl [4096];
    res_t exp_res [$];
    wr_t  exp_wr  [$];

    csr_exec_unit_if #(.XLEN(32)) bus ();

    csr_exec_unit #(.XLEN(32), .RO_CHECK(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.csr_r_val = rf[bus.csr_r_addr];

    always @(posedge clock) begin
        if (bus.csr_w_en) rf[bus.csr_w_addr] <= bus.csr_w_val;
    end

    // scoreboard monitors sample mid-cycle, away from the rising edge
    always @(negedge clock) begin
        if (reset && bus.csr_w_en) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h val=%h", bus.csr_w_addr, bus.csr_w_val);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                if (bus.csr_w_addr !== w.addr || bus.csr_w_val !== w.val) begin
                    errors++;
                    $display("FAIL write got addr=%h val=%h want addr=%h val=%h",
                             bus.csr_w_addr, bus.csr_w_val, w.addr, w.val);
                end
            end
        end
        if (reset && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_res.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result rd=%0d val=%h", bus.out_rd, bus.out_val);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                if (bus.out_rd !== r.rd || bus.out_val !== r.val || bus.out_illegal !== r.ill) begin
                    errors++;
                    $display("FAIL result got rd=%0d val=%h ill=%b want rd=%0d val=%h ill=%b",
                             bus.out_rd, bus.out_val, bus.out_illegal, r.rd, r.val, r.ill);
                end
            end
        end
    end

    function automatic void model_op(input logic [2:0] f3, input logic [11:0] addr,
                                     input logic [4:0] src, input logic [31:0] rs1,
                                     input logic [4:0] rd);
        logic [31:0] op, old, nv;
        logic        wr, ill;
        res_t        r;
        wr_t         w;
        op  = f3[2] ? {27'd0, src} : rs1;
        old = mdl[addr];
        nv  = old;
        wr  = 1'b0;
        ill = 1'b0;
        case (f3[1:0])
            2'b01: begin nv = op;         wr = 1'b1;       end
            2'b10: begin nv = old | op;   wr = (src != 0); end
            2'b11: begin nv = old & ~op;  wr = (src != 0); end
            default: ill = 1'b1;
        endcase
        if (addr[11:10] == 2'b11 && wr) ill = 1'b1;
        r.rd  = rd;
        r.val = ill ? 32'd0 : old;
        r.ill = ill;
        exp_res.push_back(r);
        if (wr && !ill) begin
            w.addr = addr;
            w.val  = nv;
            exp_wr.push_back(w);
            mdl[addr] = nv;
        end
    endfunction

    task automatic preload(input logic [11:0] addr, input logic [31:0] val);
        rf[addr]  = val;
        mdl[addr] = val;
    endtask

    // drives one request and returns #1 after its accept edge
    task automatic send(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] src,
                        input logic [31:0] rs1, input logic [4:0] rd, output int waited);
        bus.in_valid    = 1'b1;
        bus.in_funct3   = f3;
        bus.in_csr_addr = addr;
        bus.in_src_idx  = src;
        bus.in_rs1_val  = rs1;
        bus.in_rd       = rd;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
        end else begin
            model_op(f3, addr, src, rs1, rd);
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_res.size() == 0 && bus.in_ready && !bus.out_valid) && n < 60) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (exp_res.size() != 0 || !bus.in_ready || bus.out_valid) begin
            errors++;
            $display("FAIL idle_timeout pending=%0d in_ready=%b out_valid=%b required 0/1/0",
                     exp_res.size(), bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.csr_w_en !== 1'b0 ||
            bus.csr_r_addr !== 12'd0 || bus.csr_w_addr !== 12'd0 || bus.csr_w_val !== 32'd0) begin
            errors++;
            $display("FAIL reset_state rdy=%b ov=%b wen=%b ra=%h wa=%h wv=%h required all 0",
                     bus.in_ready, bus.out_valid, bus.csr_w_en, bus.csr_r_addr,
                     bus.csr_w_addr, bus.csr_w_val);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%b required=1", bus.in_ready);
        end
    endtask

    task automatic test_rw();
        int w;
        preload(CSR_MSCRATCH_ADDR, 32'h0000_00F0);
        send(F3_CSRRW, CSR_MSCRATCH_ADDR, 5'd1, 32'h1234_5678, 5'd5, w);
        checks++;
        if (bus.csr_r_addr !== CSR_MSCRATCH_ADDR || bus.csr_w_en !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_read_cycle ra=%h wen=%b ov=%b required 340/0/0",
                     bus.csr_r_addr, bus.csr_w_en, bus.out_valid);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.csr_w_en !== 1'b1 || bus.csr_w_addr !== 12'h340 || bus.csr_w_val !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rw_write_cycle wen=%b wa=%h wv=%h required 1/340/12345678",
                     bus.csr_w_en, bus.csr_w_addr, bus.csr_w_val);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.csr_w_en !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_rd !== 5'd5 ||
            bus.out_val !== 32'h0000_00F0 || bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL rw_resp wen=%b ov=%b rd=%0d val=%h ill=%b required 0/1/5/000000f0/0",
                     bus.csr_w_en, bus.out_valid, bus.out_rd, bus.out_val, bus.out_illegal);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        preload(CSR_MSCRATCH_ADDR, 32'h0000_F0F0);
        send(F3_CSRRS, CSR_MSCRATCH_ADDR, 5'd3, 32'h0F0F_0000, 5'd1, w1);
        send(F3_CSRRC, CSR_MSCRATCH_ADDR, 5'd4, 32'h0000_00F0, 5'd2, w2);
        checks++;
        if (w2 != 2) begin
            errors++;
            $display("FAIL b2b_spacing waited=%0d required=2", w2);
        end
        wait_idle();
        checks++;
        if (rf[12'h340] !== 32'h0F0F_F000) begin
            errors++;
            $display("FAIL b2b_final csr=%h required=0f0ff000", rf[12'h340]);
        end
    endtask

    task automatic test_read_only();
        int w;
        preload(CSR_MVENDORID_ADDR, 32'h0000_0F11);
        send(F3_CSRRSI, CSR_MVENDORID_ADDR, 5'd0, 32'hFFFF_FFFF, 5'd7, w);
        send(F3_CSRRWI, CSR_MVENDORID_ADDR, 5'd7, 32'h0, 5'd8, w);
        wait_idle();
        checks++;
        if (rf[12'hF11] !== 32'h0000_0F11) begin
            errors++;
            $display("FAIL ro_unchanged csr=%h required=00000f11", rf[12'hF11]);
        end
    endtask

    task automatic test_illegal_stall();
        int w, n;
        logic [4:0]  s_rd;
        logic [31:0] s_val;
        logic        s_ill;
        bus.out_ready = 1'b0;
        send(3'b100, CSR_MSCRATCH_ADDR, 5'd9, 32'hDEAD_BEEF, 5'd11, w);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clock); #1; n++;
        end
        s_rd  = bus.out_rd;
        s_val = bus.out_val;
        s_ill = bus.out_illegal;
        checks++;
        if (bus.out_valid !== 1'b1 || s_rd !== 5'd11 || s_val !== 32'd0 || s_ill !== 1'b1) begin
            errors++;
            $display("FAIL illegal_resp ov=%b rd=%0d val=%h ill=%b required 1/11/0/1",
                     bus.out_valid, s_rd, s_val, s_ill);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_rd !== s_rd ||
                bus.out_val !== s_val || bus.out_illegal !== s_ill) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d ov=%b rdy=%b rd=%0d val=%h ill=%b required 1/0/%0d/%h/%b",
                         i, bus.out_valid, bus.in_ready, bus.out_rd, bus.out_val,
                         bus.out_illegal, s_rd, s_val, s_ill);
            end
        end
        bus.out_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int w;
        preload(CSR_MSCRATCH_ADDR, 32'hAAAA_0000);
        send(F3_CSRRW, CSR_MSCRATCH_ADDR, 5'd2, 32'h0000_0055, 5'd9, w);
        @(posedge clock); #1;
        checks++;
        if (bus.csr_w_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_wen wen=%b required=1", bus.csr_w_en);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.csr_w_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset wen=%b ov=%b rdy=%b required 0/0/0",
                     bus.csr_w_en, bus.out_valid, bus.in_ready);
        end
        exp_res.delete();
        exp_wr.delete();
        mdl[12'h340] = 32'hAAAA_0000;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (rf[12'h340] !== 32'hAAAA_0000 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release csr=%h rdy=%b required aaaa0000/1", rf[12'h340], bus.in_ready);
        end
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_result ov=%b required=0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        int w;
        logic [11:0] addrs [5];
        addrs[0] = 12'h340; addrs[1] = 12'h341; addrs[2] = 12'hF11;
        addrs[3] = 12'hC00; addrs[4] = 12'h305;
        for (int i = 0; i < 5; i++) preload(addrs[i], $urandom);
        for (int i = 0; i < 30; i++) begin
            logic [4:0] src;
            src = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            send(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 4)], src,
                 $urandom, 5'($urandom_range(0, 31)), w);
        end
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rf[addrs[i]] !== mdl[addrs[i]]) begin
                errors++;
                $display("FAIL rand_final addr=%h csr=%h required=%h", addrs[i], rf[addrs[i]], mdl[addrs[i]]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            rf[i]  = 32'd0;
            mdl[i] = 32'd0;
        end
        bus.in_valid    = 1'b0;
        bus.in_funct3   = 3'd0;
        bus.in_csr_addr = 12'd0;
        bus.in_src_idx  = 5'd0;
        bus.in_rs1_val  = 32'd0;
        bus.in_rd       = 5'd0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_rw();
        test_back_to_back();
        test_read_only();
        test_illegal_stall();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL pending_writes count=%0d required=0", exp_wr.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
